// File: rtl/gpio_bus_arbiter.sv
// gpio_bus_arbiter: round-robin owner selection for the shared GPIO breakout bank.
// One requester drives the pins at a time, with an all-input turnaround cycle between owners.
// Optional feature macro: GPIO_ARB_TIMEOUT_EN. When it is defined, a grant is revoked after
// TIMEOUT_CYC cycles and the offender is masked until it drops its request.
module gpio_bus_arbiter #(
  parameter int unsigned NREQ        = 4,
  parameter int unsigned WIDTH       = 34,
  parameter int unsigned TIMEOUT_CYC = 1023
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] req_out,
  input  logic [NREQ*WIDTH-1:0] req_oeb,
  output logic [NREQ-1:0]       gnt,
  output logic [WIDTH-1:0]      gpio_out,
  output logic [WIDTH-1:0]      gpio_oeb,
  output logic                  busy,
  output logic [NREQ-1:0]       timeout_err
);

  localparam int unsigned IdxW = $clog2(NREQ);

  typedef enum logic [1:0] {StIdle, StGrant, StTurn} state_e;

  state_e          state_q, state_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [NREQ-1:0] elig;
  logic            found;
  logic [IdxW-1:0] win;
  logic [IdxW-1:0] idx;

`ifdef GPIO_ARB_TIMEOUT_EN
  localparam int unsigned     CntW    = $clog2(TIMEOUT_CYC + 1);
  // Revoking when the counter is one short keeps the grant for exactly TIMEOUT_CYC cycles.
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [NREQ-1:0] mask_q, mask_d;
  logic [NREQ-1:0] terr_q, terr_d;

  assign elig        = req & ~mask_q;
  assign timeout_err = terr_q;
`else
  logic unused_timeout_cyc;
  assign unused_timeout_cyc = ^TIMEOUT_CYC;
  assign elig        = req;
  assign timeout_err = '0;
`endif

  // Round-robin search starting just after the last winner, wrapping around.
  always_comb begin
    found = 1'b0;
    win   = last_q;
    idx   = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      idx = IdxW'((32'(last_q) + k) % NREQ);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Next-state logic for the owner FSM, grant vector and round-robin pointer.
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
`ifdef GPIO_ARB_TIMEOUT_EN
    cnt_d   = cnt_q;
    mask_d  = mask_q & req;  // a masked requester is forgiven once it lets go
    terr_d  = terr_q;
`endif
    if (!en) begin
      state_d = StIdle;
      gnt_d   = '0;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_d   = '0;
`endif
    end else begin
      unique case (state_q)
        StIdle, StTurn: begin
          state_d = StIdle;
          gnt_d   = '0;
          if (found) begin
            state_d = StGrant;
            gnt_d   = NREQ'(1) << win;
            last_d  = win;
`ifdef GPIO_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
        StGrant: begin
          if ((req & gnt_q) == '0) begin
            state_d = StTurn;
            gnt_d   = '0;
          end
`ifdef GPIO_ARB_TIMEOUT_EN
          else if (cnt_q == CntLast) begin
            state_d = StTurn;
            gnt_d   = '0;
            terr_d  = terr_q | gnt_q;
            mask_d  = mask_d | gnt_q;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
        default: begin
          state_d = StIdle;
          gnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      last_q  <= IdxW'(NREQ - 1);
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      mask_q  <= '0;
      terr_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
`ifdef GPIO_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      mask_q  <= mask_d;
      terr_q  <= terr_d;
`endif
    end
  end

  // Pin mux from the registered grant; en low floats the bank without waiting for a clock.
  always_comb begin
    gpio_out = '0;
    gpio_oeb = '1;
    if (en && (state_q == StGrant)) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (gnt_q[i]) begin
          gpio_out = req_out[i*WIDTH +: WIDTH];
          gpio_oeb = req_oeb[i*WIDTH +: WIDTH];
        end
      end
    end
  end

  assign gnt  = gnt_q;
  assign busy = (state_q == StGrant);

endmodule
